reg_transfer_unit: RTL and testbench

REG_TRANSFER_UNIT -- requirements
Module: reg_transfer_unit

---
 rtl/reg_transfer_unit.sv | 156 +++++++++++++++
 tb/tb_reg_transfer_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_transfer_unit.sv
// Register transfer unit: a register file, MDR and a registered bus.
// Moves data between registers, immediates and a handshaked memory port.
//
// Ports:
//   clk, clr                 clock, async active-low reset
//   op_valid/op_ready        operation handshake
//   op_code/op_src/op_dst/op_imm
//                            operation fields, latched at acceptance
//   mem_req/mem_we/mem_wdata memory request side
//   mem_ack/mem_rdata        memory completion side
//   bus_out, mdr             registered bus value, MDR contents
//   rd_idx/rd_data           combinational debug read port
//   err/err_clr              sticky timeout flag and its clear
module reg_transfer_unit #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int TMO     = 15,
    parameter bit ZERO_R0 = 1'b0,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [AW-1:0]    op_src,
    input  logic [AW-1:0]    op_dst,
    input  logic [WIDTH-1:0] op_imm,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] bus_out,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] mdr,
    output logic             err,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        MREQ = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_LOADI = 2'b01;
    localparam logic [1:0] OP_MEMRD = 2'b10;
    localparam logic [1:0] OP_MEMWR = 2'b11;

    state_t state, state_nx;

    logic [WIDTH-1:0] regs [NREGS];
    logic [1:0]       op_q;
    logic [AW-1:0]    src_q;
    logic [AW-1:0]    dst_q;
    logic [WIDTH-1:0] imm_q;
    logic [7:0]       cnt;
    logic             wb_pend;
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] bus_src;
    logic             accept;
    logic             tmo_hit;
    logic             dst_ok;

    assign accept  = (state == IDLE) && op_valid;
    // An ack on the final wait cycle wins over the timeout.
    assign tmo_hit = (state == MREQ) && !mem_ack && (cnt == 8'(TMO - 1));
    assign src_val = (ZERO_R0 && src_q == '0) ? '0 : regs[src_q];
    assign bus_src = (op_q == OP_LOADI) ? imm_q : src_val;
    assign rd_data = (ZERO_R0 && rd_idx == '0) ? '0 : regs[rd_idx];
    assign dst_ok  = !(ZERO_R0 && dst_q == '0);
    assign mem_wdata = mdr;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (op_valid)
                      state_nx = (op_code == OP_MEMRD) ? MREQ : XFER;
            XFER: state_nx = (op_q == OP_MEMWR) ? MREQ : IDLE;
            MREQ: begin
                if (mem_ack)
                    state_nx = (op_q == OP_MEMRD) ? WB : IDLE;
                else if (tmo_hit)
                    state_nx = IDLE;
            end
            WB:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state == IDLE);
        mem_req  = (state == MREQ);
        mem_we   = (state == MREQ) && (op_q == OP_MEMWR);
    end

    // MOVE/LOADI land in the register file one edge after XFER, from
    // bus_out, so the write completes on the next acceptance edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            op_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            cnt     <= '0;
            wb_pend <= 1'b0;
            bus_out <= '0;
            mdr     <= '0;
            err     <= 1'b0;
        end else begin
            wb_pend <= 1'b0;
            if (wb_pend && dst_ok) regs[dst_q] <= bus_out;
            if (accept) begin
                op_q  <= op_code;
                src_q <= op_src;
                dst_q <= op_dst;
                imm_q <= op_imm;
            end
            unique case (state)
                XFER: begin
                    bus_out <= bus_src;
                    if (op_q == OP_MEMWR) mdr <= bus_src;
                    else                  wb_pend <= 1'b1;
                end
                MREQ: begin
                    if (mem_ack) begin
                        cnt <= '0;
                        if (op_q == OP_MEMRD) mdr <= mem_rdata;
                    end else if (tmo_hit) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WB: begin
                    bus_out <= mdr;
                    if (dst_ok) regs[dst_q] <= mdr;
                end
                default: ;
            endcase
            if (tmo_hit)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_transfer_unit.sv
// Testbench for reg_transfer_unit: directed and random operations
// checked against a register-level behavioural model.
module tb_reg_transfer_unit;
    localparam int W = 32;
    localparam int N = 16;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         clr;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [1:0]   op_code = '0;
    logic [3:0]   op_src = '0;
    logic [3:0]   op_dst = '0;
    logic [W-1:0] op_imm = '0;
    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_wdata;
    logic         mem_ack = 1'b0;
    logic [W-1:0] mem_rdata = '0;
    logic [W-1:0] bus_out;
    logic [3:0]   rd_idx = '0;
    logic [W-1:0] rd_data;
    logic [W-1:0] mdr;
    logic         err;
    logic         err_clr = 1'b0;

    always #5 clk = ~clk;

    reg_transfer_unit #(
        .WIDTH(W), .NREGS(N), .TMO(T), .ZERO_R0(1'b1)
    ) dut (
        .clk(clk), .clr(clr),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_src(op_src), .op_dst(op_dst),
        .op_imm(op_imm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_out(bus_out), .rd_idx(rd_idx), .rd_data(rd_data),
        .mdr(mdr), .err(err), .err_clr(err_clr)
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0] m_regs [N];
    logic [W-1:0] m_mdr;
    logic         m_err;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // R0 is hardwired to zero in this configuration.
    function automatic logic [W-1:0] rv(input int i);
        return (i == 0) ? '0 : m_regs[i];
    endfunction

    function automatic void mw(input int i, input logic [W-1:0] v);
        if (i != 0) m_regs[i] = v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all;
        for (int i = 0; i < N; i++) begin
            rd_idx = 4'(i);
            tick;
            chk($sformatf("reg%0d", i), rd_data, rv(i));
        end
    endtask

    // ack_at: MREQ cycle (0-based) carrying mem_ack; >= T means none.
    task automatic op(input logic [1:0] c, input int s, input int d,
                      input logic [W-1:0] imm, input int ack_at,
                      input logic [W-1:0] rdata);
        logic [W-1:0] v;
        bit acked;
        chk("ready_idle", op_ready, 1);
        op_valid = 1'b1;
        op_code  = c;
        op_src   = 4'(s);
        op_dst   = 4'(d);
        op_imm   = imm;
        rd_idx   = 4'(d);
        v = (c == 2'b01) ? imm : rv(s);
        tick;
        op_valid = 1'b0;
        op_code  = 2'($urandom);
        op_src   = 4'($urandom);
        op_dst   = 4'($urandom);
        op_imm   = $urandom;
        if (c != 2'b10) begin
            chk("ready_xfer", op_ready, 0);
            tick;
            chk("bus_xfer", bus_out, v);
            if (c == 2'b11) begin
                m_mdr = v;
            end else begin
                mw(d, v);
                chk("ready_after", op_ready, 1);
                return;
            end
        end
        acked = 1'b0;
        for (int k = 0; k < T && !acked; k++) begin
            chk("mem_req", mem_req, 1);
            chk("mem_we", mem_we, {31'd0, c == 2'b11});
            if (c == 2'b11) chk("mem_wdata", mem_wdata, v);
            if (k == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                acked     = 1'b1;
            end else begin
                mem_rdata = $urandom;
            end
            tick;
            mem_ack = 1'b0;
        end
        chk("req_done", mem_req, 0);
        if (!acked) begin
            m_err = 1'b1;
            chk("err_tmo", err, 1);
            chk("ready_tmo", op_ready, 1);
            chk("mdr_tmo", mdr, m_mdr);
        end else if (c == 2'b11) begin
            chk("ready_wr", op_ready, 1);
        end else begin
            m_mdr = rdata;
            chk("mdr_rd", mdr, rdata);
            chk("ready_wb", op_ready, 0);
            tick;
            mw(d, rdata);
            chk("bus_wb", bus_out, rdata);
            chk("rd_wb", rd_data, rv(d));
            chk("ready_post_wb", op_ready, 1);
        end
        chk("err", err, m_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_mdr = '0;
        m_err = 1'b0;
        clr = 1'b1;
        #2 clr = 1'b0;
        tick;
        tick;
        chk("rst_ready", op_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_bus", bus_out, 0);
        chk("rst_mdr", mdr, 0);
        chk("rst_err", err, 0);
        clr = 1'b1;
        chk("rel_ready", op_ready, 1);

        // LOADI then back-to-back MOVE
        op(2'b01, 0, 3, 32'hDEADBEEF, 0, 0);
        op(2'b00, 3, 7, 0, 0, 0);
        tick;
        chk("r7_move", rd_data, 32'hDEADBEEF);

        // MEMRD with ack on cycle 2, then on the timeout edge
        op(2'b10, 0, 5, 0, 2, 32'h12345678);
        op(2'b10, 0, 6, 0, T - 1, 32'h0BADF00D);
        chk("err_prec", err, 0);

        // MEMWR
        op(2'b01, 0, 2, 32'hA5A5A5A5, 0, 0);
        op(2'b11, 2, 0, 0, 2, 0);

        // timeout then clear
        op(2'b10, 0, 9, 0, 99, 32'hFFFF0000);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_clr", err, 0);

        // R0 hardwired
        op(2'b01, 0, 0, 32'hFFFFFFFF, 0, 0);
        tick;
        rd_idx = 4'd0;
        tick;
        chk("r0_zero", rd_data, 0);
        op(2'b00, 0, 4, 0, 0, 0);
        op(2'b10, 0, 0, 0, 1, 32'h55AA55AA);

        // MOVE onto itself
        op(2'b00, 7, 7, 0, 0, 0);

        // stray ack while idle
        tick;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick;
        mem_ack = 1'b0;
        chk("stray_mdr", mdr, m_mdr);
        chk("stray_ready", op_ready, 1);
        check_all;

        for (int n = 0; n < 60; n++) begin
            op(2'($urandom_range(0, 3)), $urandom_range(0, N - 1),
               $urandom_range(0, N - 1), $urandom,
               $urandom_range(0, T + 1), $urandom);
        end
        check_all;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_clr2", err, 0);

        // reset during MREQ, then a late ack
        op_valid = 1'b1;
        op_code  = 2'b10;
        op_dst   = 4'd6;
        tick;
        op_valid = 1'b0;
        chk("pre_rst_req", mem_req, 1);
        tick;
        clr = 1'b0;
        #1;
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_mdr = '0;
        chk("mrst_req", mem_req, 0);
        chk("mrst_we", mem_we, 0);
        chk("mrst_ready", op_ready, 1);
        chk("mrst_bus", bus_out, 0);
        chk("mrst_mdr", mdr, 0);
        chk("mrst_err", err, 0);
        tick;
        clr = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h87654321;
        tick;
        mem_ack = 1'b0;
        chk("late_ack_mdr", mdr, 0);
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_ready", op_ready, 1);
        check_all;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
